// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: FSM state encoding, bubble/halt
// constants and the opcode field position inside an instruction word.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_LOAD   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: 2**ADDR_W x 32 words, combinational read, synchronous write.
// Contents are not reset so a loaded program survives a core reset.
module instruction_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage with PC, instruction memory, IF/ID register and a run/halt/load
// debug FSM. Optional perf counters are built when IF_PERF_COUNTERS_EN is defined.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter logic [5:0]  HALT_OPCODE = mips_pkg::HALT_OPCODE,
    parameter logic [31:0] NOP_WORD    = mips_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              if_id_write,
    input  logic              jump_take,
    input  logic [31:0]       jump_addr,
    input  logic              branch_take,
    input  logic [31:0]       branch_addr,
    input  logic              stop_debug,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              load_start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              load_done,
`ifdef IF_PERF_COUNTERS_EN
    output logic [31:0]       outFetchCount,
    output logic [31:0]       outStallCount,
`endif
    output logic [31:0]       outInstruction,
    output logic [31:0]       outNextInstructionAddress,
    output logic [31:0]       outPC,
    output logic              outHalted
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  r_next_addr;

    logic [31:0]  w_mem_rdata;
    logic [31:0]  w_pc_inc;
    logic         w_mem_we;
    logic         w_is_halt;
    logic         w_step_open;
    logic         w_fetch;
    logic         w_run;

    instruction_memory #(.ADDR_W(ADDR_W)) u_imem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (r_pc[ADDR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    assign w_run     = (r_state == ST_RUN) && !load_start;
    assign w_pc_inc  = r_pc + 32'd1;
    assign w_is_halt = (w_mem_rdata[OPC_MSB:OPC_LSB] == HALT_OPCODE);
    assign w_mem_we  = load_we && (r_state == ST_LOAD) && !stop_debug;
    // In step mode a request seen while the PC is held is spent without fetching.
    assign w_step_open = !step_mode || (step_req && pc_write);
    assign w_fetch     = w_run && !branch_take && if_id_write && w_step_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pc        <= 32'd0;
            r_instr     <= NOP_WORD;
            r_next_addr <= 32'd0;
        end else if (!stop_debug) begin
            case (r_state)
                ST_RUN: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_instr <= NOP_WORD;
                    end else begin
                        if (branch_take) begin
                            r_pc <= branch_addr;
                        end else if (jump_take) begin
                            r_pc <= jump_addr;
                        end else if (pc_write && w_step_open && !(w_fetch && w_is_halt)) begin
                            r_pc <= w_pc_inc;
                        end

                        if (branch_take) begin
                            r_instr     <= NOP_WORD;
                            r_next_addr <= 32'd0;
                        end else if (if_id_write) begin
                            if (!w_step_open) begin
                                r_instr <= NOP_WORD;
                            end else begin
                                r_instr     <= w_mem_rdata;
                                r_next_addr <= w_pc_inc;
                                if (w_is_halt) begin
                                    r_state <= ST_HALTED;
                                end
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    r_instr <= NOP_WORD;
                    if (load_start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_instr <= NOP_WORD;
                    if (load_done && !load_start) begin
                        r_state     <= ST_RUN;
                        r_pc        <= 32'd0;
                        r_next_addr <= 32'd0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else if (!stop_debug) begin
            if ((r_state == ST_LOAD) && load_done && !load_start) begin
                r_fetch_cnt <= 32'd0;
                r_stall_cnt <= 32'd0;
            end else begin
                if (w_fetch) begin
                    r_fetch_cnt <= r_fetch_cnt + 32'd1;
                end
                if ((r_state == ST_RUN) && !pc_write) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end
    end

    assign outFetchCount = r_fetch_cnt;
    assign outStallCount = r_stall_cnt;
`endif

    assign outInstruction            = r_instr;
    assign outNextInstructionAddress = r_next_addr;
    assign outPC                     = r_pc;
    assign outHalted                 = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: program load, halt, stalls, jump/branch
// redirects, single-step, debug freeze and reset during load.
module tb_instruction_fetch;

    localparam int ADDR_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              pc_write, if_id_write;
    logic              jump_take, branch_take;
    logic [31:0]       jump_addr, branch_addr;
    logic              stop_debug, step_mode, step_req;
    logic              load_start, load_we, load_done;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [31:0]       outInstruction, outNextInstructionAddress, outPC;
    logic              outHalted;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0]       outFetchCount, outStallCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pw, iw, jt;
        logic [31:0] ja;
        logic        bt;
        logic [31:0] ba;
        logic        sm, sr;
        logic [31:0] e_instr, e_nia, e_pc;
        logic        e_halt;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(ADDR_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .pc_write                  (pc_write),
        .if_id_write               (if_id_write),
        .jump_take                 (jump_take),
        .jump_addr                 (jump_addr),
        .branch_take               (branch_take),
        .branch_addr               (branch_addr),
        .stop_debug                (stop_debug),
        .step_mode                 (step_mode),
        .step_req                  (step_req),
        .load_start                (load_start),
        .load_we                   (load_we),
        .load_addr                 (load_addr),
        .load_data                 (load_data),
        .load_done                 (load_done),
`ifdef IF_PERF_COUNTERS_EN
        .outFetchCount             (outFetchCount),
        .outStallCount             (outStallCount),
`endif
        .outInstruction            (outInstruction),
        .outNextInstructionAddress (outNextInstructionAddress),
        .outPC                     (outPC),
        .outHalted                 (outHalted)
    );

    function automatic vec_t mk(input logic pw, iw, jt, input logic [31:0] ja,
                                input logic bt, input logic [31:0] ba,
                                input logic sm, sr,
                                input logic [31:0] ei, en, ep, input logic eh);
        vec_t v;
        v.pw = pw; v.iw = iw; v.jt = jt; v.ja = ja; v.bt = bt; v.ba = ba;
        v.sm = sm; v.sr = sr; v.e_instr = ei; v.e_nia = en; v.e_pc = ep; v.e_halt = eh;
        return v;
    endfunction

    function automatic vec_t mkn(input logic [31:0] ei, en, ep, input logic eh);
        return mk(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, ei, en, ep, eh);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ei, en, ep, input logic eh);
        chk({tag, ".instr"}, outInstruction, ei);
        chk({tag, ".nia"}, outNextInstructionAddress, en);
        chk({tag, ".pc"}, outPC, ep);
        chk({tag, ".halted"}, {31'd0, outHalted}, {31'd0, eh});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        pc_write = v.pw; if_id_write = v.iw;
        jump_take = v.jt; jump_addr = v.ja;
        branch_take = v.bt; branch_addr = v.ba;
        step_mode = v.sm; step_req = v.sr;
        tick();
        chk_all(tag, v.e_instr, v.e_nia, v.e_pc, v.e_halt);
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk_all(tag, NOP, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        // Program A: three plain words then a halt word.
        tab_a.push_back(mkn(32'd1, 32'd1, 32'd1, 1'b0));
        tab_a.push_back(mkn(32'd2, 32'd2, 32'd2, 1'b0));
        tab_a.push_back(mkn(32'd3, 32'd3, 32'd3, 1'b0));
        tab_a.push_back(mkn(32'hFC00_0000, 32'd4, 32'd3, 1'b1));
        tab_a.push_back(mkn(NOP, 32'd4, 32'd3, 1'b1));
        tab_a.push_back(mkn(NOP, 32'd4, 32'd3, 1'b1));
        tab_a.push_back(mk(1, 1, 0, 32'd0, 1, 32'h10, 0, 0, NOP, 32'd4, 32'd3, 1'b1));
        tab_a.push_back(mk(1, 1, 1, 32'h20, 0, 32'd0, 0, 0, NOP, 32'd4, 32'd3, 1'b1));

        // Program B: mem[i] = 0x100 + i.
        for (int i = 0; i < 5; i++)
            tab_b.push_back(mkn(32'h100 + i, i + 1, i + 1, 1'b0));
        tab_b.push_back(mk(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 32'h104, 32'd5, 32'd5, 1'b0));
        tab_b.push_back(mk(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 32'h104, 32'd5, 32'd5, 1'b0));
        for (int i = 5; i < 9; i++)
            tab_b.push_back(mkn(32'h100 + i, i + 1, i + 1, 1'b0));
        tab_b.push_back(mk(1, 1, 1, 32'h40, 0, 32'd0, 0, 0, 32'h109, 32'hA, 32'h40, 1'b0));
        tab_b.push_back(mkn(32'h140, 32'h41, 32'h41, 1'b0));
        tab_b.push_back(mk(1, 1, 1, 32'h30, 1, 32'h20, 0, 0, NOP, 32'd0, 32'h20, 1'b0));
        tab_b.push_back(mkn(32'h120, 32'h21, 32'h21, 1'b0));
        for (int s = 0; s < 3; s++) begin
            tab_b.push_back(mk(1, 1, 0, 32'd0, 0, 32'd0, 1, 1, 32'h121 + s, 32'h22 + s, 32'h22 + s, 1'b0));
            tab_b.push_back(mk(1, 1, 0, 32'd0, 0, 32'd0, 1, 0, NOP, 32'h22 + s, 32'h22 + s, 1'b0));
            tab_b.push_back(mk(1, 1, 0, 32'd0, 0, 32'd0, 1, 0, NOP, 32'h22 + s, 32'h22 + s, 1'b0));
        end
        tab_b.push_back(mk(0, 1, 0, 32'd0, 0, 32'd0, 1, 1, NOP, 32'h24, 32'h24, 1'b0));
        tab_b.push_back(mkn(32'h124, 32'h25, 32'h25, 1'b0));

        // Clock/reset; load_start waits on the first edge after release.
        rst = 1'b1;
        pc_write = 1'b1; if_id_write = 1'b1;
        jump_take = 1'b0; jump_addr = '0; branch_take = 1'b0; branch_addr = '0;
        stop_debug = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        load_start = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        #3;
        chk_all("reset", NOP, 32'd0, 32'd0, 1'b0);
        #9 rst = 1'b0;
        tick();
        load_start = 1'b0;

        write_word(8'd0, 32'd1);
        write_word(8'd1, 32'd2);
        write_word(8'd2, 32'd3);
        write_word(8'd3, 32'hFC00_0000);
        finish_load("load_a_done");
        foreach (tab_a[i]) apply(tab_a[i], $sformatf("prog_a[%0d]", i));

        // Reload from HALTED.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_from_halt.halted", {31'd0, outHalted}, 32'd0);
        for (int i = 0; i <= 64; i++) write_word(i[ADDR_W-1:0], 32'h100 + i);
        finish_load("load_b_done");
        foreach (tab_b[i]) apply(tab_b[i], $sformatf("prog_b[%0d]", i));

        // Load from RUN, then freeze while a write and load_done are presented.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk_all("load_from_run", NOP, 32'h25, 32'h25, 1'b0);
        write_word(8'h22, 32'hCAFE_0001);
        stop_debug = 1'b1; load_done = 1'b1;
        load_we = 1'b1; load_addr = 8'h21; load_data = 32'hDEAD_BEEF;
        tick();
        chk_all("frozen", NOP, 32'h25, 32'h25, 1'b0);

        // Asynchronous reset mid-load.
        rst = 1'b1;
        #2;
        chk_all("rst_mid_load", NOP, 32'd0, 32'd0, 1'b0);
        stop_debug = 1'b0; load_done = 1'b0; load_we = 1'b0;
        branch_take = 1'b1; branch_addr = 32'h21;
        rst = 1'b0;
        tick();
        chk_all("post_rst_branch", NOP, 32'd0, 32'h21, 1'b0);
        branch_take = 1'b0;
        tick();
        chk_all("stop_blocked_write", 32'h121, 32'h22, 32'h22, 1'b0);
        tick();
        chk_all("retained_write", 32'hCAFE_0001, 32'h23, 32'h23, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- MIPS IF stage, directly upstream of the decode stage.
- Holds the PC and a combinational-read instruction memory, and drives the IF/ID pipeline register (instruction, PC+1).
- Consumes hazard stall, jump redirect (from decode) and branch redirect (from execute).
- Adds a run/step/halt/load FSM for the debug unit, including program loading over a write port.

Parameters:
- ADDR_W, 8, instruction memory word-address width (depth = 2**ADDR_W words).
- HALT_OPCODE, 6'b111111, opcode that halts fetch.
- NOP_WORD, 32'h0000_0000, bubble instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge (decode samples on falling edge).
- rst  in  1  reset, asynchronous, active-high.
- pc_write  in  1  hazard unit: 0 = hold PC.
- if_id_write  in  1  hazard unit: 0 = hold IF/ID register.
- jump_take  in  1  decode: jump redirect.
- jump_addr  in  32  decode: jump target (word address).
- branch_take  in  1  execute: branch redirect, flushes IF/ID.
- branch_addr  in  32  execute: branch target (word address).
- stop_debug  in  1  freeze all state.
- step_mode  in  1  1 = single-step operation.
- step_req  in  1  one-cycle pulse: allow one fetch in step mode.
- load_start  in  1  pulse: enter LOAD state.
- load_we  in  1  memory write strobe (LOAD state only).
- load_addr  in  ADDR_W  memory write address.
- load_data  in  32  memory write data.
- load_done  in  1  pulse: leave LOAD, PC=0, enter RUN.
- outInstruction  out  32  IF/ID instruction.
- outNextInstructionAddress  out  32  IF/ID PC+1.
- outPC  out  32  current PC.
- outHalted  out  1  FSM in HALTED.

Behaviour:
- PC counts words; next sequential PC = PC+1 with 32-bit wrap (FFFF_FFFF -> 0).
- Memory address = PC[ADDR_W-1:0]; upper PC bits are ignored.
- Reset: PC=0, outInstruction=NOP_WORD, outNextInstructionAddress=0, FSM=RUN, outHalted=0. Memory contents are not cleared.
- FSM states: RUN, HALTED, LOAD. stop_debug=1 freezes PC, IF/ID, FSM and memory writes.
- RUN, PC update priority (highest first):
  - branch_take: PC <= branch_addr.
  - jump_take: PC <= jump_addr.
  - pc_write=0 or step gate closed: hold.
  - otherwise: PC+1.
- RUN, IF/ID update priority (highest first):
  - branch_take: instruction <= NOP_WORD, next-address <= 0.
  - if_id_write=0: hold.
  - step gate closed: instruction <= NOP_WORD, next-address held.
  - otherwise: instruction <= mem[PC], next-address <= PC+1.
- Jump does not flush IF/ID (decode-stage jump; the delay slot executes). branch_take and jump_take in the same cycle: branch wins.
- Step gate: open when step_mode=0, or when step_mode=1 and step_req=1 in that cycle. Each step_req pulse yields exactly one fetch. A step_req arriving while pc_write=0 is consumed with no fetch.
- Halt:
  - When mem[PC][31:26]==HALT_OPCODE is captured into IF/ID, the FSM goes RUN->HALTED on the same edge.
  - The halt word reaches decode once; PC is not incremented past it.
  - In HALTED, IF/ID loads NOP_WORD every cycle and PC holds.
  - Branch/jump inputs are ignored in HALTED.
- Load:
  - load_start in RUN or HALTED -> LOAD. In LOAD, IF/ID = NOP_WORD and PC holds.
  - load_we writes mem[load_addr] <= load_data on the edge; load_we outside LOAD is ignored.
  - load_done -> RUN with PC=0 and IF/ID=NOP_WORD.
  - load_start and load_done in the same cycle: load_start wins.
- rst asserted mid-load or mid-step: immediate return to reset values. Partially loaded memory contents are retained.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- Defined:
  - Adds output ports outFetchCount[31:0] (increments on each real fetch into IF/ID) and outStallCount[31:0] (increments on each RUN cycle with pc_write=0).
  - Both counters reset to 0, wrap at 2^32, freeze under stop_debug, and clear on load_done.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - FSM state enum (ST_RUN, ST_HALTED, ST_LOAD).
  - NOP_WORD and HALT_OPCODE constants.
  - Opcode field slice constants (OPC_MSB=31, OPC_LSB=26).
- One sub-module, instruction_memory: 2**ADDR_W x 32, combinational read port, synchronous write port.

Test Plan:
- Reset, then load mem[0..3] = 1,2,3,FC00_0000, then load_done, run 6 cycles -> outInstruction sequence 1,2,3,FC00_0000 with next-address 1,2,3,4; outHalted=1 after the 4th fetch; NOPs thereafter; PC stays 3.
- pc_write=0 and if_id_write=0 for 2 cycles at PC=5 -> PC stays 5; IF/ID holds mem[4] and next-address 5; resumes with mem[5].
- jump_take=1, jump_addr=0x40 at PC=9 -> PC=0x40 next cycle; IF/ID gets mem[9] (delay slot, not flushed).
- branch_take and jump_take together, branch_addr=0x20 -> PC=0x20; IF/ID=NOP_WORD, next-address 0.
- step_mode=1, step_req pulsed every 3rd cycle over 9 cycles -> exactly 3 fetches; NOP_WORD in the gated cycles; PC advances by 3.
- stop_debug held during load_we, then rst mid-load -> no memory write during stop; after rst, PC=0, FSM=RUN, outInstruction=NOP_WORD.
